// File: rtl/dmem_bridge.sv
// Bridges the core's single-cycle data-memory port onto a valid/ready bus.
// The core is held frozen while each load or store completes one bus transaction.
//
// state | meaning
// IDLE  | core runs; a load/store with en_in high is captured and launched
// REQ   | req_valid high, captured request fields held until req_ready
// RESP  | waiting for the single response to the outstanding request
// REL   | core released for one enabled cycle; load data lands on exit
module dmem_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  output logic              cpu_en,
  input  logic [3:0]        cpu_mem_write_en,
  input  logic              cpu_mem_read_en,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_mem_write_data,
  output logic [DATA_W-1:0] cpu_mem_read_data,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [3:0]        req_wstrb,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_rdata,
  input  logic              resp_err,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr,
  output logic [31:0]       stall_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_REL  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              is_write;
  logic              access;
  logic              launch;
  logic              cpu_en_fsm;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_pend;

  assign is_write = |cpu_mem_write_en;
  assign access   = cpu_mem_read_en | is_write;
  assign launch   = (state_q == S_IDLE) & en_in & access;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cpu_en_fsm = 1'b0;
    req_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cpu_en_fsm = en_in & ~access;
        if (en_in && access) state_d = S_REQ;
      end
      S_REQ: begin
        req_valid = 1'b1;
        if (req_ready) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_valid) state_d = S_REL;
      end
      S_REL: begin
        cpu_en_fsm = en_in;
        if (en_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IDLE would otherwise let cpu_en follow en_in while reset is still held
  assign cpu_en = cpu_en_fsm & rst;

  // Write wins over read when both are presented
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_we    <= 1'b0;
      req_wstrb <= 4'b0000;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (launch) begin
      req_we    <= is_write;
      req_wstrb <= is_write ? cpu_mem_write_en : 4'b0000;
      req_addr  <= cpu_mem_addr;
      req_wdata <= cpu_mem_write_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_pend <= '0;
      err_flag   <= 1'b0;
      err_addr   <= '0;
    end else if (state_q == S_RESP && resp_valid) begin
      if (!req_we) rdata_pend <= resp_rdata;
      if (resp_err && !err_flag) begin
        err_flag <= 1'b1;
        err_addr <= req_addr;
      end
    end
  end

  // Load data becomes visible only after REL, keeping M-stage data stable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  rdata_q <= '0;
    else if (state_q == S_REL && en_in && !req_we) rdata_q <= rdata_pend;
  end

  assign cpu_mem_read_data = rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                           stall_count <= '0;
    else if (en_in && !cpu_en && stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
  end

endmodule
